reg_write_queue: RTL and testbench

- Write-back buffer directly upstream of the 64-entry physical register file.
- Collects results from two execution lanes into a small in-order FIFO.
- Drains up to two entries per cycle onto registered write-port signals (enable, 6-bit select, 32-bit data) that drive the register file write ports.
- Write-back is decoupled from execution timing; drain is gated by a commit/write-allow signal.

---
 rtl/reg_write_queue.sv | 146 ++++++++++++++
 tb/tb_reg_write_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_queue.sv
// Write-back queue: collects two lanes of results in order and drains up to two per cycle to the register file.
// Latency: 2 cycles minimum from input to registered write-port outputs; drain gated by writeAllow.
// Backpressure: inReady drops when fewer than two entries are free; inputs arriving then are dropped and set sticky overflow.
// Optional build macro REG_WRITE_QUEUE_DROP_ZERO_EN: discard results targeting register 0 at enqueue.
module reg_write_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inValid0,
    input  logic [TAG_W-1:0]           inTag0,
    input  logic [DATA_W-1:0]          inData0,
    input  logic                       inValid1,
    input  logic [TAG_W-1:0]           inTag1,
    input  logic [DATA_W-1:0]          inData1,
    output logic                       inReady,
    input  logic                       writeAllow,
    output logic                       writeEn0,
    output logic [TAG_W-1:0]           writeSelect0,
    output logic [DATA_W-1:0]          writeData0,
    output logic                       writeEn1,
    output logic [TAG_W-1:0]           writeSelect1,
    output logic [DATA_W-1:0]          writeData1,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage has no reset: entries are only read once counted as occupied.
    logic [TAG_W-1:0]  mem_tag_q  [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wen0_q, wen0_d, wen1_q, wen1_d;
    logic [TAG_W-1:0]  sel0_q, sel0_d, sel1_q, sel1_d;
    logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;

    logic              lane_vld0, lane_vld1;
    logic              in_ready;
    logic              wr_en0, wr_en1;
    logic [PTR_W-1:0]  wr_idx0, wr_idx1, rd_idx1;
    logic [1:0]        enq, deq;

    // Qualify lane valids; optionally filter writes aimed at the hardwired-zero register.
    always_comb begin
        lane_vld0 = inValid0;
        lane_vld1 = inValid1;
`ifdef REG_WRITE_QUEUE_DROP_ZERO_EN
        lane_vld0 = inValid0 && (inTag0 != '0);
        lane_vld1 = inValid1 && (inTag1 != '0);
`endif
    end

    // Enqueue side: readiness from registered count only; lane 1 compacts down when lane 0 is idle.
    always_comb begin
        in_ready   = (count_q <= CNT_W'(DEPTH - 2));
        wr_en0     = in_ready && lane_vld0;
        wr_en1     = in_ready && lane_vld1;
        wr_idx0    = wr_ptr_q;
        wr_idx1    = wr_ptr_q + (lane_vld0 ? PTR_W'(1) : PTR_W'(0));
        enq        = {1'b0, wr_en0} + {1'b0, wr_en1};
        overflow_d = overflow_q || (!in_ready && (lane_vld0 || lane_vld1));
    end

    // Dequeue side: pop up to two, but split a same-tag pair so both ports never target one register.
    always_comb begin
        rd_idx1 = rd_ptr_q + PTR_W'(1);
        if (!writeAllow || (count_q == '0)) begin
            deq = 2'd0;
        end else if (count_q == CNT_W'(1)) begin
            deq = 2'd1;
        end else if (mem_tag_q[rd_ptr_q] == mem_tag_q[rd_idx1]) begin
            deq = 2'd1;
        end else begin
            deq = 2'd2;
        end

        wen0_d = (deq != 2'd0);
        wen1_d = (deq == 2'd2);
        sel0_d = wen0_d ? mem_tag_q[rd_ptr_q]  : sel0_q;
        dat0_d = wen0_d ? mem_data_q[rd_ptr_q] : dat0_q;
        sel1_d = wen1_d ? mem_tag_q[rd_idx1]   : sel1_q;
        dat1_d = wen1_d ? mem_data_q[rd_idx1]  : dat1_q;

        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    // Entry storage writes; the two lane slots are always distinct indices.
    always_ff @(posedge clk) begin
        if (wr_en0) begin
            mem_tag_q[wr_idx0]  <= inTag0;
            mem_data_q[wr_idx0] <= inData0;
        end
        if (wr_en1) begin
            mem_tag_q[wr_idx1]  <= inTag1;
            mem_data_q[wr_idx1] <= inData1;
        end
    end

    // Control state and registered write ports; reset cancels any drain immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wen0_q     <= 1'b0;
            wen1_q     <= 1'b0;
            sel0_q     <= '0;
            sel1_q     <= '0;
            dat0_q     <= '0;
            dat1_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wen0_q     <= wen0_d;
            wen1_q     <= wen1_d;
            sel0_q     <= sel0_d;
            sel1_q     <= sel1_d;
            dat0_q     <= dat0_d;
            dat1_q     <= dat1_d;
        end
    end

    assign inReady      = in_ready;
    assign writeEn0     = wen0_q;
    assign writeSelect0 = sel0_q;
    assign writeData0   = dat0_q;
    assign writeEn1     = wen1_q;
    assign writeSelect1 = sel1_q;
    assign writeData1   = dat1_q;
    assign count        = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue (DEPTH=8, TAG_W=6, DATA_W=32).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Honours REG_WRITE_QUEUE_DROP_ZERO_EN to select the expected zero-tag behaviour.
module tb_reg_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid0, inValid1, writeAllow;
    logic [5:0]  inTag0, inTag1;
    logic [31:0] inData0, inData1;
    logic        inReady, writeEn0, writeEn1, overflow;
    logic [5:0]  writeSelect0, writeSelect1;
    logic [31:0] writeData0, writeData1;
    logic [3:0]  count;

    int n_pass = 0;
    int n_tot  = 0;

    reg_write_queue #(.DEPTH(8), .TAG_W(6), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inValid0(inValid0), .inTag0(inTag0), .inData0(inData0),
        .inValid1(inValid1), .inTag1(inTag1), .inData1(inData1),
        .inReady(inReady), .writeAllow(writeAllow),
        .writeEn0(writeEn0), .writeSelect0(writeSelect0), .writeData0(writeData0),
        .writeEn1(writeEn1), .writeSelect1(writeSelect1), .writeData1(writeData1),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inValid0 = 1'b0; inTag0 = '0; inData0 = '0;
        inValid1 = 1'b0; inTag1 = '0; inData1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        writeAllow = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            n_tot++; if (count !== 4'd0) $display("FAIL reset_count cyc%0d got %0d want 0", i, count); else n_pass++;
            n_tot++; if (inReady !== 1'b1) $display("FAIL reset_inReady cyc%0d got %b want 1", i, inReady); else n_pass++;
            n_tot++; if (writeEn0 !== 1'b0 || writeEn1 !== 1'b0) $display("FAIL reset_writeEn cyc%0d got %b%b want 00", i, writeEn0, writeEn1); else n_pass++;
            n_tot++; if (overflow !== 1'b0) $display("FAIL reset_overflow cyc%0d got %b want 0", i, overflow); else n_pass++;
            cyc();
        end
    endtask

    task automatic test_dual_lane();
        do_reset();
        writeAllow = 1'b1;
        inValid0 = 1'b1; inTag0 = 6'd5; inData0 = 32'hAAAA0001;
        inValid1 = 1'b1; inTag1 = 6'd9; inData1 = 32'hBBBB0002;
        cyc();
        idle_inputs();
        n_tot++; if (count !== 4'd2) $display("FAIL dual_count_after_enq got %0d want 2", count); else n_pass++;
        cyc();
        n_tot++; if (writeEn0 !== 1'b1 || writeSelect0 !== 6'd5 || writeData0 !== 32'hAAAA0001)
            $display("FAIL dual_port0 got en=%b sel=%0d data=%h want en=1 sel=5 data=aaaa0001", writeEn0, writeSelect0, writeData0); else n_pass++;
        n_tot++; if (writeEn1 !== 1'b1 || writeSelect1 !== 6'd9 || writeData1 !== 32'hBBBB0002)
            $display("FAIL dual_port1 got en=%b sel=%0d data=%h want en=1 sel=9 data=bbbb0002", writeEn1, writeSelect1, writeData1); else n_pass++;
        n_tot++; if (count !== 4'd0) $display("FAIL dual_count_after_drain got %0d want 0", count); else n_pass++;
        cyc();
        n_tot++; if (writeEn0 !== 1'b0 || writeEn1 !== 1'b0) $display("FAIL dual_empty_en got %b%b want 00", writeEn0, writeEn1); else n_pass++;
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            inValid0 = 1'b1; inTag0 = 6'(2*k + 1); inData0 = 32'hD0000000 + 32'(2*k + 1);
            inValid1 = 1'b1; inTag1 = 6'(2*k + 2); inData1 = 32'hD0000000 + 32'(2*k + 2);
            if (k == 3) begin
                n_tot++; if (inReady !== 1'b1) $display("FAIL full_ready_at6 got %b want 1", inReady); else n_pass++;
            end
            cyc();
        end
        idle_inputs();
        n_tot++; if (count !== 4'd8) $display("FAIL full_count got %0d want 8", count); else n_pass++;
        n_tot++; if (inReady !== 1'b0) $display("FAIL full_inReady got %b want 0", inReady); else n_pass++;
        inValid0 = 1'b1; inTag0 = 6'd12; inData0 = 32'h0000000C;
        cyc();
        idle_inputs();
        n_tot++; if (overflow !== 1'b1) $display("FAIL full_overflow got %b want 1", overflow); else n_pass++;
        n_tot++; if (count !== 4'd8) $display("FAIL full_count_after_drop got %0d want 8", count); else n_pass++;
        writeAllow = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_tot++; if (writeEn0 !== 1'b1 || writeSelect0 !== 6'(2*k + 1) || writeData0 !== 32'hD0000000 + 32'(2*k + 1))
                $display("FAIL full_drain%0d_port0 got en=%b sel=%0d data=%h want sel=%0d", k, writeEn0, writeSelect0, writeData0, 2*k + 1); else n_pass++;
            n_tot++; if (writeEn1 !== 1'b1 || writeSelect1 !== 6'(2*k + 2) || writeData1 !== 32'hD0000000 + 32'(2*k + 2))
                $display("FAIL full_drain%0d_port1 got en=%b sel=%0d data=%h want sel=%0d", k, writeEn1, writeSelect1, writeData1, 2*k + 2); else n_pass++;
            n_tot++; if (count !== 4'(6 - 2*k)) $display("FAIL full_drain%0d_count got %0d want %0d", k, count, 6 - 2*k); else n_pass++;
        end
        cyc();
        n_tot++; if (writeEn0 !== 1'b0 || writeEn1 !== 1'b0) $display("FAIL full_no_extra_write got %b%b sel0=%0d want 00", writeEn0, writeEn1, writeSelect0); else n_pass++;
        n_tot++; if (overflow !== 1'b1) $display("FAIL full_overflow_sticky got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_same_tag();
        do_reset();
        writeAllow = 1'b1;
        inValid0 = 1'b1; inTag0 = 6'd7; inData0 = 32'd1;
        inValid1 = 1'b1; inTag1 = 6'd7; inData1 = 32'd2;
        cyc();
        idle_inputs();
        cyc();
        n_tot++; if (writeEn0 !== 1'b1 || writeSelect0 !== 6'd7 || writeData0 !== 32'd1)
            $display("FAIL same_tag_A_port0 got en=%b sel=%0d data=%0d want en=1 sel=7 data=1", writeEn0, writeSelect0, writeData0); else n_pass++;
        n_tot++; if (writeEn1 !== 1'b0) $display("FAIL same_tag_A_port1_en got %b want 0", writeEn1); else n_pass++;
        n_tot++; if (count !== 4'd1) $display("FAIL same_tag_A_count got %0d want 1", count); else n_pass++;
        cyc();
        n_tot++; if (writeEn0 !== 1'b1 || writeSelect0 !== 6'd7 || writeData0 !== 32'd2)
            $display("FAIL same_tag_B_port0 got en=%b sel=%0d data=%0d want en=1 sel=7 data=2", writeEn0, writeSelect0, writeData0); else n_pass++;
        n_tot++; if (writeEn1 !== 1'b0) $display("FAIL same_tag_B_port1_en got %b want 0", writeEn1); else n_pass++;
    endtask

    task automatic test_wrap_stream();
        logic [5:0]  got_tag[$];
        logic [31:0] got_dat[$];
        int max_cnt = 0;
        do_reset();
        writeAllow = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) begin
                inValid0 = 1'b1; inTag0 = 6'((i*7 + 3) % 64); inData0 = 32'h50000000 + 32'(i);
            end else begin
                idle_inputs();
            end
            cyc();
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (writeEn0 === 1'b1) begin got_tag.push_back(writeSelect0); got_dat.push_back(writeData0); end
            if (writeEn1 === 1'b1) begin got_tag.push_back(writeSelect1); got_dat.push_back(writeData1); end
        end
        n_tot++; if (got_tag.size() != 20) $display("FAIL wrap_out_count got %0d want 20", got_tag.size()); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (i < got_tag.size()) begin
                n_tot++; if (got_tag[i] !== 6'((i*7 + 3) % 64) || got_dat[i] !== 32'h50000000 + 32'(i))
                    $display("FAIL wrap_item%0d got sel=%0d data=%h want sel=%0d data=%h", i, got_tag[i], got_dat[i], (i*7 + 3) % 64, 32'h50000000 + 32'(i)); else n_pass++;
            end
        end
        n_tot++; if (max_cnt > 2) $display("FAIL wrap_max_count got %0d want <=2", max_cnt); else n_pass++;
        n_tot++; if (overflow !== 1'b0) $display("FAIL wrap_overflow got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        inValid0 = 1'b1; inTag0 = 6'd20; inData0 = 32'h20;
        inValid1 = 1'b1; inTag1 = 6'd21; inData1 = 32'h21;
        cyc();
        inTag0 = 6'd22; inData0 = 32'h22; inTag1 = 6'd23; inData1 = 32'h23;
        cyc();
        idle_inputs();
        writeAllow = 1'b1;
        cyc();
        n_tot++; if (writeEn0 !== 1'b1 || writeSelect0 !== 6'd20) $display("FAIL middrain_pre got en=%b sel=%0d want en=1 sel=20", writeEn0, writeSelect0); else n_pass++;
        reset = 1'b1;
        #1;
        n_tot++; if (writeEn0 !== 1'b0 || writeEn1 !== 1'b0) $display("FAIL middrain_async_en got %b%b want 00", writeEn0, writeEn1); else n_pass++;
        n_tot++; if (writeSelect0 !== 6'd0 || writeData0 !== 32'd0 || writeSelect1 !== 6'd0 || writeData1 !== 32'd0)
            $display("FAIL middrain_async_port got sel0=%0d d0=%h sel1=%0d d1=%h want all 0", writeSelect0, writeData0, writeSelect1, writeData1); else n_pass++;
        n_tot++; if (count !== 4'd0) $display("FAIL middrain_async_count got %0d want 0", count); else n_pass++;
        #1 reset = 1'b0;
        cyc();
        n_tot++; if (writeEn0 !== 1'b0 || writeEn1 !== 1'b0) $display("FAIL middrain_cancelled got %b%b want 00", writeEn0, writeEn1); else n_pass++;
    endtask

    task automatic test_zero_tag();
        do_reset();
        inValid0 = 1'b1; inTag0 = 6'd0; inData0 = 32'h11;
        inValid1 = 1'b1; inTag1 = 6'd3; inData1 = 32'h33;
        cyc();
        idle_inputs();
`ifdef REG_WRITE_QUEUE_DROP_ZERO_EN
        n_tot++; if (count !== 4'd1) $display("FAIL zero_count got %0d want 1", count); else n_pass++;
        writeAllow = 1'b1;
        cyc();
        n_tot++; if (writeEn0 !== 1'b1 || writeSelect0 !== 6'd3 || writeData0 !== 32'h33)
            $display("FAIL zero_port0 got en=%b sel=%0d data=%h want en=1 sel=3 data=33", writeEn0, writeSelect0, writeData0); else n_pass++;
        n_tot++; if (writeEn1 !== 1'b0) $display("FAIL zero_port1_en got %b want 0", writeEn1); else n_pass++;
`else
        n_tot++; if (count !== 4'd2) $display("FAIL zero_count got %0d want 2", count); else n_pass++;
        writeAllow = 1'b1;
        cyc();
        n_tot++; if (writeEn0 !== 1'b1 || writeSelect0 !== 6'd0 || writeData0 !== 32'h11)
            $display("FAIL zero_port0 got en=%b sel=%0d data=%h want en=1 sel=0 data=11", writeEn0, writeSelect0, writeData0); else n_pass++;
        n_tot++; if (writeEn1 !== 1'b1 || writeSelect1 !== 6'd3 || writeData1 !== 32'h33)
            $display("FAIL zero_port1 got en=%b sel=%0d data=%h want en=1 sel=3 data=33", writeEn1, writeSelect1, writeData1); else n_pass++;
`endif
        n_tot++; if (overflow !== 1'b0) $display("FAIL zero_overflow got %b want 0", overflow); else n_pass++;
        cyc();
        n_tot++; if (writeEn0 !== 1'b0 || count !== 4'd0) $display("FAIL zero_drained got en0=%b count=%0d want 0/0", writeEn0, count); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        writeAllow = 1'b0;
        idle_inputs();
        test_reset();
        test_dual_lane();
        test_full_overflow();
        test_same_tag();
        test_wrap_stream();
        test_reset_mid_drain();
        test_zero_tag();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
